// File: rtl/oclib_bc_arbiter_if.sv
// Byte-channel bundle between N upstream requesters and one shared downstream link.
// "in" signals enter the arbiter and "out" signals leave it.
interface oclib_bc_arbiter_if #(
  parameter int Ports = 2
);
  logic [Ports-1:0][7:0] up_in_data;
  logic [Ports-1:0]      up_in_valid;
  logic [Ports-1:0]      up_in_ready;
  logic [Ports-1:0][7:0] up_out_data;
  logic [Ports-1:0]      up_out_valid;
  logic [Ports-1:0]      up_out_ready;
  logic [7:0]            down_in_data;
  logic                  down_in_valid;
  logic                  down_in_ready;
  logic [7:0]            down_out_data;
  logic                  down_out_valid;
  logic                  down_out_ready;

  modport master (
    output up_in_data, up_in_valid, up_in_ready,
    output down_in_data, down_in_valid, down_in_ready,
    input  up_out_data, up_out_valid, up_out_ready,
    input  down_out_data, down_out_valid, down_out_ready
  );

  modport slave (
    input  up_in_data, up_in_valid, up_in_ready,
    input  down_in_data, down_in_valid, down_in_ready,
    output up_out_data, up_out_valid, up_out_ready,
    output down_out_data, down_out_valid, down_out_ready
  );
endinterface

// File: rtl/oclib_bc_arbiter.sv
// Round-robin message arbiter that shares one length-prefixed byte channel among Ports requesters.
// Optional response watchdog: define OC_BC_ARBITER_TIMEOUT_EN.
module oclib_bc_arbiter #(
  parameter int Ports         = 2,
  parameter int TimeoutCycles = 1024,
  localparam int PW           = (Ports > 1) ? $clog2(Ports) : 1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  oclib_bc_arbiter_if.slave bc,
  output logic [PW-1:0]     grant_o,
  output logic              busy_o,
  output logic              timeout_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_LEN = 3'd1,
    REQ_PAY = 3'd2,
    RSP_LEN = 3'd3,
    RSP_PAY = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] grant_q, grant_d;
  logic [PW-1:0] last_q, last_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [PW-1:0] pick;
  logic [PW:0]   cand;
  logic          any_req;
  logic          req_ph, rsp_ph;
  logic          req_xfer, rsp_xfer;
  logic [7:0]    req_byte, rsp_byte;
  logic          tmo_hit;

  // Search starts one past the last owner so a continuously requesting port waits at most Ports messages.
  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int k = 1; k <= Ports; k++) begin
      cand = {1'b0, last_q} + (PW+1)'(k);
      if (cand >= (PW+1)'(Ports)) cand = cand - (PW+1)'(Ports);
      if (!any_req && bc.up_in_valid[cand[PW-1:0]]) begin
        pick    = cand[PW-1:0];
        any_req = 1'b1;
      end
    end
  end

  assign req_ph   = (state_q == REQ_LEN) || (state_q == REQ_PAY);
  assign rsp_ph   = (state_q == RSP_LEN) || (state_q == RSP_PAY);
  assign req_byte = bc.up_in_data[grant_q];
  assign rsp_byte = bc.down_in_data;
  assign req_xfer = req_ph && bc.up_in_valid[grant_q] && bc.down_in_ready;
  assign rsp_xfer = rsp_ph && bc.down_in_valid && bc.up_in_ready[grant_q];

`ifdef OC_BC_ARBITER_TIMEOUT_EN
  logic [31:0] idle_q, idle_d;
  logic        tmo_q;

  // Counter is held at zero outside the response phase, which covers the reset on RSP_LEN entry.
  assign tmo_hit = rsp_ph && !rsp_xfer && (idle_q == 32'(TimeoutCycles - 1));

  always_comb begin
    idle_d = '0;
    if (rsp_ph && !rsp_xfer) idle_d = idle_q + 32'd1;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      idle_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      idle_q <= idle_d;
      tmo_q  <= tmo_hit;
    end
  end

  assign timeout_o = tmo_q;
`else
  assign tmo_hit   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= PW'(Ports - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = pick;
          state_d = REQ_LEN;
        end
      end
      REQ_LEN: begin
        if (req_xfer) begin
          cnt_d   = req_byte;
          state_d = (req_byte == 8'd0) ? RSP_LEN : REQ_PAY;
        end
      end
      REQ_PAY: begin
        if (req_xfer) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = RSP_LEN;
        end
      end
      RSP_LEN: begin
        if (rsp_xfer) begin
          cnt_d = rsp_byte;
          if (rsp_byte == 8'd0) begin
            state_d = IDLE;
            last_d  = grant_q;
          end else begin
            state_d = RSP_PAY;
          end
        end
      end
      RSP_PAY: begin
        if (rsp_xfer) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = IDLE;
            last_d  = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (tmo_hit) begin
      state_d = IDLE;
      last_d  = grant_q;
    end
  end

  // Pure muxes: a granted path adds no register stage in either direction.
  always_comb begin
    bc.down_out_data  = '0;
    bc.down_out_valid = 1'b0;
    bc.down_out_ready = 1'b0;
    bc.up_out_data    = '0;
    bc.up_out_valid   = '0;
    bc.up_out_ready   = '0;
    if (req_ph) begin
      bc.down_out_data           = req_byte;
      bc.down_out_valid          = bc.up_in_valid[grant_q];
      bc.up_out_ready[grant_q]   = bc.down_in_ready;
    end
    if (rsp_ph) begin
      bc.up_out_data[grant_q]    = rsp_byte;
      bc.up_out_valid[grant_q]   = bc.down_in_valid;
      bc.down_out_ready          = bc.up_in_ready[grant_q];
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_oclib_bc_arbiter.sv
// Directed bench for oclib_bc_arbiter: queue-driven requesters/responder, message-level model, per-cycle compare.
module tb_oclib_bc_arbiter;
  localparam int P = 3;
`ifdef OC_BC_ARBITER_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] grant;
  logic       busy, timeout;

  always #5 clock = ~clock;

  oclib_bc_arbiter_if #(.Ports(P)) bc ();

  oclib_bc_arbiter #(.Ports(P), .TimeoutCycles(TMO)) dut (
    .clock_i   (clock),
    .reset_i   (reset),
    .bc        (bc),
    .grant_o   (grant),
    .busy_o    (busy),
    .timeout_o (timeout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_seq(input string nm, input logic [7:0] q[$], input int n, input logic [31:0] exp);
    chk({nm, "_len"}, 64'(q.size()), 64'(n));
    for (int k = 0; k < n && k < q.size(); k++)
      chk(nm, 64'(q[k]), 64'(exp[8*(n-1-k) +: 8]));
  endtask

  // stimulus queues and logs
  logic [7:0] rq [P][$];
  logic [7:0] rsp [$];
  logic [7:0] dlog [$];
  logic [7:0] ulog [P][$];
  logic [7:0] glog [$];
  int         sent [P];
  int         stall_at [P];
  int         stall_left [P];
  bit         dr_toggle = 1'b0;
  int         tmo_seen = 0;

  // model state
  int m_owner = -1, m_g = 0, m_last = P - 1, m_phase = 0, m_left = -1, m_idle = 0;
  bit m_tmo = 1'b0, armed = 1'b0;
  int cyc_n = 0, m_rsp_entry = 0, m_tmo_cyc = 0;

  // driver: consume handshakes at the edge, drive new values 1 time unit later
  initial begin
    for (int i = 0; i < P; i++) begin
      sent[i] = 0; stall_at[i] = -1; stall_left[i] = 0;
    end
    bc.up_in_data = '0; bc.up_in_valid = '0; bc.up_in_ready = '1;
    bc.down_in_data = '0; bc.down_in_valid = 1'b0; bc.down_in_ready = 1'b1;
    forever begin
      @(posedge clock);
      if (!reset) begin
        for (int i = 0; i < P; i++) begin
          if (bc.up_in_valid[i] && bc.up_out_ready[i]) begin
            void'(rq[i].pop_front());
            sent[i]++;
          end
          if (bc.up_out_valid[i] && bc.up_in_ready[i]) ulog[i].push_back(bc.up_out_data[i]);
        end
        if (bc.down_out_valid && bc.down_in_ready) dlog.push_back(bc.down_out_data);
        if (bc.down_in_valid && bc.down_out_ready) void'(rsp.pop_front());
        if (timeout) tmo_seen++;
      end
      #1;
      for (int i = 0; i < P; i++) begin
        if (rq[i].size() > 0) begin
          bc.up_in_data[i] = rq[i][0];
          if (sent[i] == stall_at[i] && stall_left[i] > 0) begin
            bc.up_in_valid[i] = 1'b0;
            stall_left[i]--;
          end else begin
            bc.up_in_valid[i] = 1'b1;
          end
        end else begin
          bc.up_in_data[i]  = '0;
          bc.up_in_valid[i] = 1'b0;
        end
      end
      bc.down_in_valid = (rsp.size() > 0);
      bc.down_in_data  = (rsp.size() > 0) ? rsp[0] : 8'h00;
      bc.down_in_ready = dr_toggle ? ~bc.down_in_ready : 1'b1;
    end
  end

  // message-level model: who owns the link, which half of the exchange, bytes still owed
  initial begin
    int c;
    forever begin
      @(posedge clock);
      cyc_n++;
      m_tmo = 1'b0;
      if (reset) begin
        m_owner = -1; m_g = 0; m_last = P - 1; m_left = -1; m_idle = 0; armed = 1'b1;
      end else if (m_owner < 0) begin
        for (int k = 1; k <= P; k++) begin
          c = (m_last + k) % P;
          if (m_owner < 0 && bc.up_in_valid[c]) m_owner = c;
        end
        if (m_owner >= 0) begin
          m_g = m_owner; m_phase = 0; m_left = -1;
          glog.push_back(8'(m_owner));
        end
      end else if (m_phase == 0) begin
        if (bc.up_in_valid[m_owner] && bc.down_in_ready) begin
          m_left = (m_left < 0) ? int'(bc.up_in_data[m_owner]) : m_left - 1;
          if (m_left == 0) begin
            m_phase = 1; m_left = -1; m_idle = 0; m_rsp_entry = cyc_n;
          end
        end
      end else begin
        if (bc.down_in_valid && bc.up_in_ready[m_owner]) begin
          m_idle = 0;
          m_left = (m_left < 0) ? int'(bc.down_in_data) : m_left - 1;
          if (m_left == 0) begin
            m_last = m_owner; m_owner = -1;
          end
        end else begin
          m_idle++;
`ifdef OC_BC_ARBITER_TIMEOUT_EN
          if (m_idle == TMO) begin
            m_last = m_owner; m_owner = -1; m_tmo = 1'b1; m_tmo_cyc = cyc_n;
          end
`endif
        end
      end
    end
  end

  // per-cycle compare on the falling edge
  initial begin
    logic [7:0]         edd;
    logic               edv, edr;
    logic [P-1:0][7:0]  eud;
    logic [P-1:0]       euv, eur;
    forever begin
      @(negedge clock);
      if (armed) begin
        edd = '0; edv = 1'b0; edr = 1'b0; eud = '0; euv = '0; eur = '0;
        if (m_owner >= 0 && m_phase == 0) begin
          edd = bc.up_in_data[m_owner];
          edv = bc.up_in_valid[m_owner];
          eur[m_owner] = bc.down_in_ready;
        end else if (m_owner >= 0) begin
          eud[m_owner] = bc.down_in_data;
          euv[m_owner] = bc.down_in_valid;
          edr = bc.up_in_ready[m_owner];
        end
        chk("down_bus", 64'({bc.down_out_data, bc.down_out_valid, bc.down_out_ready}), 64'({edd, edv, edr}));
        chk("up_bus", 64'({bc.up_out_data, bc.up_out_valid, bc.up_out_ready}), 64'({eud, euv, eur}));
        chk("status", 64'({grant, busy, timeout}), 64'({2'(m_g), (m_owner >= 0), m_tmo}));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic bit stim_empty();
    bit e = (rsp.size() == 0);
    for (int i = 0; i < P; i++) if (rq[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic wait_done(input string nm, input int budget);
    bit done = 1'b0;
    for (int t = 0; t < budget && !done; t++) begin
      cyc(1);
      done = (m_owner < 0) && stim_empty();
    end
    if (!done) chk({nm, "_hang"}, 64'd0, 64'd1);
  endtask

  task automatic clear_logs();
    dlog.delete(); glog.delete();
    for (int i = 0; i < P; i++) ulog[i].delete();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < P; i++) begin
      rq[i].delete(); sent[i] = 0; stall_at[i] = -1; stall_left[i] = 0;
    end
    rsp.delete();
    clear_logs();
    cyc(n);
    reset = 1'b0;
  endtask

  initial begin
    bit ok;
    cyc(1);
    do_reset(3);
    chk("reset_grant", 64'(grant), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);

    // single message, port 0
    rq[0] = {8'h02, 8'hAA, 8'hBB};
    rsp   = {8'h01, 8'hCC};
    wait_done("t1", 60);
    chk_seq("t1_down", dlog, 3, 32'h0002AABB);
    chk_seq("t1_up0", ulog[0], 2, 32'h000001CC);
    chk_seq("t1_grant", glog, 1, 32'h00000000);

    // two continuous requesters alternate
    do_reset(2);
    rq[0] = {8'h00, 8'h00};
    rq[1] = {8'h00, 8'h00};
    rsp   = {8'h00, 8'h00, 8'h00, 8'h00};
    wait_done("t2", 80);
    chk_seq("t2_grant", glog, 4, 32'h00010001);

    // stalled requester and toggling downstream ready
    clear_logs();
    sent[1] = 0; stall_at[1] = 2; stall_left[1] = 2;
    dr_toggle = 1'b1;
    rq[1] = {8'h03, 8'h11, 8'h22, 8'h33};
    rsp   = {8'h00};
    wait_done("t3", 80);
    dr_toggle = 1'b0;
    cyc(1);
    chk_seq("t3_down", dlog, 4, 32'h03112233);
    chk_seq("t3_grant", glog, 1, 32'h00000001);

    // early response bytes held off; port 0 arrives during port 1 response
    clear_logs();
    rq[1] = {8'h01, 8'h55};
    rsp   = {8'h02, 8'hD1, 8'hD2, 8'h00};
    ok = 1'b0;
    for (int t = 0; t < 60 && !ok; t++) begin
      cyc(1);
      ok = (m_owner == 1 && m_phase == 1);
    end
    chk("t4_reach_rsp", 64'(ok), 64'd1);
    rq[0] = {8'h00};
    wait_done("t4", 80);
    chk_seq("t4_grant", glog, 2, 32'h00000100);
    chk_seq("t4_up1", ulog[1], 3, 32'h0002D1D2);
    chk_seq("t4_up0", ulog[0], 1, 32'h00000000);
    chk_seq("t4_down", dlog, 3, 32'h00015500);

    // reset mid-payload
    clear_logs();
    rq[0] = {8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
    ok = 1'b0;
    for (int t = 0; t < 60 && !ok; t++) begin
      cyc(1);
      ok = (m_owner == 0 && m_phase == 0 && m_left >= 1 && m_left <= 3);
    end
    chk("t5_reach_pay", 64'(ok), 64'd1);
    do_reset(1);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_grant", 64'(grant), 64'd0);
    chk("t5_dvalid", 64'(bc.down_out_valid), 64'd0);
    rq[0] = {8'h00};
    rq[1] = {8'h00};
    rsp   = {8'h00, 8'h00};
    wait_done("t5", 60);
    chk_seq("t5_grant_seq", glog, 2, 32'h00000001);
    chk_seq("t5_down", dlog, 2, 32'h00000000);

`ifdef OC_BC_ARBITER_TIMEOUT_EN
    // unanswered request is abandoned, next requester served
    clear_logs();
    tmo_seen = 0;
    rq[0] = {8'h00};
    wait_done("t6", TMO + 40);
    chk("t6_tmo_pulses", 64'(tmo_seen), 64'd1);
    chk("t6_tmo_delay", 64'(m_tmo_cyc - m_rsp_entry), 64'd16);
    rq[1] = {8'h00};
    rsp   = {8'h00};
    wait_done("t6b", 40);
    chk_seq("t6_grant", glog, 2, 32'h00000001);
    chk_seq("t6_up1", ulog[1], 1, 32'h00000000);
`else
    chk("no_timeout", 64'(tmo_seen), 64'd0);
`endif

    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
